instruction_fetch: RTL
======================

# instruction_fetch

Fetch stage directly upstream of the instruction decoder. It owns the program counter, issues reads to a synchronous program memory with one-cycle latency, and buffers returned words in a 3-entry prefetch queue. It presents one instruction per cycle to the decoder over a valid/ready handshake. Jump redirects and a halt request from the execute side control the fetch pointer.

## Interface
- `INS_W`, default 13: instruction width, matching the decoder input width.
- `PC_W`, default 8: program counter and program memory address width.

Ports:
- `Clk` in 1: clock; all state changes on the rising edge.
- `nRst` in 1: reset, asynchronous, active-low.
- `PM_Addr` out `PC_W`: program memory read address, equal to the registered fetch pointer `FPC`.
- `PM_RdEn` out 1: read strobe. Data for a read issued in cycle t appears on `PM_Data` in cycle t+1.
- `PM_Data` in `INS_W`: program memory read data.
- `Ins` out `INS_W`: instruction at the queue head; all zeros when `InsValid`=0.
- `InsPC` out `PC_W`: address of `Ins`; all zeros when `InsValid`=0.
- `InsValid` out 1: queue non-empty.
- `InsReady` in 1: decoder accepts. A pop occurs when `InsValid` and `InsReady` are both 1.
- `JmpEn` in 1: redirect request, sampled on the clock edge.
- `JmpAddr` in `PC_W`: redirect target.
- `Halt` in 1: level request to stop issuing reads.

## Operation
- State machine has three states:
  - `RESET`: held while `nRst`=0.
  - `RUN`: issuing reads.
  - `HALT`: no reads issued.
  - `RESET`→`RUN` on the first edge after `nRst` deasserts.
  - `RUN`→`HALT` when `Halt`=1; `HALT`→`RUN` when `Halt`=0. The transition takes effect on the next edge, so issue gating is combinational on `Halt`.
- Reset values:
  - `FPC`=0, queue count=0, `InFlight`=0, `Squash`=0.
  - Outputs: `PM_RdEn`=0, `PM_Addr`=0, `Ins`=0, `InsPC`=0, `InsValid`=0.
- Issue rule: `PM_RdEn` = state is `RUN` and `Halt`=0 and `JmpEn`=0 and (count + `InFlight`) < 3.
  - The rule uses registered count and `InFlight` only; there is no `InsReady` path to `PM_RdEn`.
  - On issue: `FPC` <= `FPC`+1 modulo 2^`PC_W` (255 wraps to 0), and `InFlight` <= 1. Otherwise `InFlight` <= 0.
- Return: when `InFlight`=1 and `Squash`=0, the cycle's `PM_Data` and its issue address are pushed to the queue tail.
  - The issue rule guarantees a push never targets a full queue.
- Push and pop in the same cycle: count is unchanged. The head and tail pointers wrap modulo 3.
- Redirect, when `JmpEn`=1 at an edge:
  - Queue flushed (count <= 0).
  - `FPC` <= `JmpAddr`.
  - `Squash` <= `InFlight`-to-be, i.e. the read issued in this cycle (if any) is discarded when it returns.
  - A pop in the same cycle still counts as a completed handshake for the decoder, then the queue is flushed.
  - Redirect has priority over push, pop and increment.
- `Squash` clears on the edge after it discards a return.
- Halt:
  - An outstanding read still returns and is queued.
  - Queue contents are held and can still be popped.
  - A redirect while halted updates `FPC` and flushes, and fetch resumes at `JmpAddr` once `Halt`=0.
- Asynchronous reset mid-operation: all state returns to its reset values immediately, and in-flight data is ignored.

## Timing
- Reset release (first edge = edge 0):
  - Cycle 0: `PM_RdEn`=1, `PM_Addr`=0.
  - Cycle 1: data returns and is pushed; address 1 is issued.
  - Cycle 2: `InsValid`=1, `Ins`=word@0, `InsPC`=0.
- Steady state with `InsReady`=1: one instruction per cycle; count oscillates at 1 with one read in flight.
- Stall (`InsReady`=0): the queue fills to 3 within 2 cycles and `PM_RdEn` drops. After `InsReady` returns, issue resumes the next cycle with no bubble at `Ins`.
- Jump penalty: `JmpEn` in cycle t → `InsValid`=0 in t+1 and t+2 → `Ins`=word@`JmpAddr` in t+3.

## Test plan
- Reset release with memory word@n = n+0x100, `InsReady`=1 → `InsValid` first rises in cycle 2. `InsPC` then reads 0,1,2,… on consecutive cycles, with `Ins`=0x100,0x101,….
- `InsReady`=0 for 6 cycles from cycle 4 → `PM_RdEn` low once count=3. No instruction is lost or duplicated, and the `InsPC` sequence resumes contiguously.
- `JmpEn`=1, `JmpAddr`=0x40 while the queue is full and a read is in flight → outputs are invalid for two cycles, then `InsPC`=0x40, 0x41, …, and no squashed word ever appears.
- Start at `FPC`=0xFE via a jump → `InsPC` sequence 0xFE, 0xFF, 0x00, 0x01.
- `Halt`=1 for 5 cycles with `InsReady`=1 → the queue drains, `PM_RdEn` stays 0 and `InsValid` drops. After release, fetch continues from the next sequential address. A jump to 0x10 during the halt yields 0x10 after release.
- `nRst` pulsed low mid-stream for 1 cycle → all outputs are 0 at once, and the cycle-2 reset sequence from address 0 repeats.

Source files
------------

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the program counter, issues one-cycle-latency reads to the
// program memory and buffers returned words in a 3-entry prefetch queue that
// feeds the decoder over a valid/ready handshake.
module instruction_fetch #(
   parameter int INS_W = 13,
   parameter int PC_W  = 8
) (
   input  logic             Clk,
   input  logic             nRst,
   output logic [PC_W-1:0]  PM_Addr,
   output logic             PM_RdEn,
   input  logic [INS_W-1:0] PM_Data,
   output logic [INS_W-1:0] Ins,
   output logic [PC_W-1:0]  InsPC,
   output logic             InsValid,
   input  logic             InsReady,
   input  logic             JmpEn,
   input  logic [PC_W-1:0]  JmpAddr,
   input  logic             Halt
);

   typedef enum logic [1:0] {
      ST_RESET,
      ST_RUN,
      ST_HALT
   } state_t;

   state_t           state;
   state_t           state_next;
   logic [PC_W-1:0]  fpc;
   logic [PC_W-1:0]  issue_pc;
   logic             in_flight;
   logic             squash;
   logic [1:0]       count;
   logic [1:0]       head;
   logic [1:0]       tail;
   logic [INS_W-1:0] q_ins [3];
   logic [PC_W-1:0]  q_pc  [3];
   logic             issue;
   logic             push;
   logic             pop;

   function automatic logic [1:0] wrap_inc(input logic [1:0] p);
      return (p == 2'd2) ? 2'd0 : p + 2'd1;
   endfunction

   // Fetch control state register
   always_ff @(posedge Clk or negedge nRst) begin
      if (!nRst) state <= ST_RESET;
      else       state <= state_next;
   end

   // Next-state logic: leave reset immediately, follow the Halt level afterwards
   always_comb begin
      state_next = state;
      case (state)
         ST_RESET: state_next = ST_RUN;
         ST_RUN:   state_next = Halt ? ST_HALT : ST_RUN;
         ST_HALT:  state_next = Halt ? ST_HALT : ST_RUN;
         default:  state_next = ST_RESET;
      endcase
   end

   // Issue only when the queue plus the outstanding read leaves room for the return
   always_comb begin
      issue = (state == ST_RUN) && !Halt && !JmpEn &&
              (({1'b0, count} + {2'b00, in_flight}) < 3'd3);
      push  = in_flight && !squash;
      pop   = InsValid && InsReady;
   end

   // Fetch pointer, outstanding-read tracking and squash of reads issued alongside a redirect
   always_ff @(posedge Clk or negedge nRst) begin
      if (!nRst) begin
         fpc       <= '0;
         issue_pc  <= '0;
         in_flight <= 1'b0;
         squash    <= 1'b0;
      end else begin
         in_flight <= issue;
         if (issue) issue_pc <= fpc;
         if (JmpEn) begin
            fpc    <= JmpAddr;
            squash <= issue;
         end else begin
            if (issue) fpc <= fpc + 1'b1;
            if (squash && in_flight) squash <= 1'b0;
         end
      end
   end

   // Queue occupancy and pointers; a redirect flushes everything
   always_ff @(posedge Clk or negedge nRst) begin
      if (!nRst) begin
         count <= '0;
         head  <= '0;
         tail  <= '0;
      end else if (JmpEn) begin
         count <= '0;
         head  <= '0;
         tail  <= '0;
      end else begin
         if (push) tail <= wrap_inc(tail);
         if (pop)  head <= wrap_inc(head);
         case ({push, pop})
            2'b10:   count <= count + 2'd1;
            2'b01:   count <= count - 2'd1;
            default: count <= count;
         endcase
      end
   end

   // Queue storage; stale entries are never visible because the outputs are masked by count
   always_ff @(posedge Clk) begin
      if (push && !JmpEn) begin
         q_ins[tail] <= PM_Data;
         q_pc[tail]  <= issue_pc;
      end
   end

   // Decoder-facing outputs, zeroed whenever the queue is empty
   always_comb begin
      InsValid = (count != 2'd0);
      Ins      = InsValid ? q_ins[head] : '0;
      InsPC    = InsValid ? q_pc[head]  : '0;
      PM_Addr  = fpc;
      PM_RdEn  = issue;
   end

endmodule
